vending_change: RTL



---
 rtl/vending_pkg.sv | 34 +++
 rtl/vending_timer.sv | 44 ++++
 rtl/vending_change.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Purpose  : Shared coin codes, coin values and FSM state encoding for the
//            vending change dispenser.
// Revision : 1.0
// ============================================================================
package vending_pkg;

    localparam logic [1:0] COIN_1    = 2'b00;
    localparam logic [1:0] COIN_2    = 2'b01;
    localparam logic [1:0] COIN_4    = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  coin_value = 3'd1;
            COIN_2:  coin_value = 3'd2;
            COIN_4:  coin_value = 3'd4;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vending_timer.sv
`default_nettype none
// ============================================================================
// Module   : vending_timer
// Purpose  : Clearable up-counter with terminal-count compare, shared between
//            the ack timeout and the inter-coin gap.
// Revision : 1.0
// ============================================================================
module vending_timer
    import vending_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == tc_val);

endmodule
`default_nettype wire

// File: rtl/vending_change.sv
`default_nettype none
// ============================================================================
// Module   : vending_change
// Purpose  : Pays out an owed amount one coin at a time (greedy 4/2/1) over a
//            valid/ack handshake with a fixed gap and a sticky ack timeout.
//            Define VEND_CHANGE_STAT_EN to build the coins_paid counter.
// Revision : 1.0
// ============================================================================
module vending_change
    import vending_pkg::*;
#(
    parameter int AMT_W   = 4,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             err_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remaining,
    output logic [7:0]       coins_paid
);

    localparam int T_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [TMR_W-1:0] TO_TC  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_TC = TMR_W'(GAP - 1);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       coin_out_q, coin_out_d;
    logic             coin_valid_q, coin_valid_d;
    logic             err_q, err_d;
    logic [1:0]       greedy_code;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [TMR_W-1:0] tmr_tc_val;

    // AMT_W is assumed to be at least 3 so the value 4 is representable.
    always_comb begin
        if (remaining_q >= AMT_W'(4)) begin
            greedy_code = COIN_4;
        end else if (remaining_q >= AMT_W'(2)) begin
            greedy_code = COIN_2;
        end else begin
            greedy_code = COIN_1;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        err_d        = err_q;
        tmr_clr      = 1'b1;
        tmr_en       = 1'b0;
        tmr_tc_val   = GAP_TC;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    coin_out_d   = greedy_code;
                    coin_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_clr    = 1'b0;
                tmr_en     = 1'b1;
                tmr_tc_val = TO_TC;
                // Ack is checked first so it wins over a coincident timeout.
                if (coin_ack) begin
                    remaining_d  = remaining_q - AMT_W'(coin_value(coin_out_q));
                    coin_valid_d = 1'b0;
                    coin_out_d   = COIN_NONE;
                    tmr_clr      = 1'b1;
                    state_d      = ST_GAP;
                end else if (tmr_tc) begin
                    coin_valid_d = 1'b0;
                    coin_out_d   = COIN_NONE;
                    err_d        = 1'b1;
                    state_d      = ST_FAULT;
                end
            end
            ST_GAP: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (err_clr) begin
                    err_d       = 1'b0;
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            coin_out_q   <= COIN_NONE;
            coin_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            err_q        <= err_d;
        end
    end

    vending_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tmr_tc_val),
        .tc     (tmr_tc)
    );

`ifdef VEND_CHANGE_STAT_EN
    logic       coin_accept;
    logic [7:0] coins_paid_q, coins_paid_d;

    assign coin_accept = (state_q == ST_ISSUE) && coin_ack;

    always_comb begin
        coins_paid_d = coins_paid_q;
        if (coin_accept && (coins_paid_q != 8'hFF)) begin
            coins_paid_d = coins_paid_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coins_paid_q <= 8'd0;
        end else begin
            coins_paid_q <= coins_paid_d;
        end
    end

    assign coins_paid = coins_paid_q;
`else
    assign coins_paid = 8'd0;
`endif

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign err        = err_q;
    assign remaining  = remaining_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign done       = (state_q == ST_DONE);

endmodule
`default_nettype wire
